// File: rtl/i2c_target.sv
// I2C target endpoint with a fixed 7-bit address: synchronizes SDA/SCL, detects START/STOP,
// receives write bytes, serves read bytes from user logic and drives ACKs open-drain style.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sda,
    input  logic       i_scl,
    output logic       o_sda_drive,
    output logic       o_start,
    output logic       o_stop,
    output logic       o_busy,
    output logic       o_wr_valid,
    output logic [7:0] o_wr_data,
    output logic       o_tx_req,
    input  logic [7:0] i_tx_data
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic                   sda_prev_reg;
    logic                   scl_prev_reg;

    // Synchronizer chains reset to the idle bus level so reset never fakes an edge.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge i_clk) begin
                    if (i_rst) begin
                        sda_sync_reg[gi] <= 1'b1;
                        scl_sync_reg[gi] <= 1'b1;
                    end else begin
                        sda_sync_reg[gi] <= i_sda;
                        scl_sync_reg[gi] <= i_scl;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge i_clk) begin
                    if (i_rst) begin
                        sda_sync_reg[gi] <= 1'b1;
                        scl_sync_reg[gi] <= 1'b1;
                    end else begin
                        sda_sync_reg[gi] <= sda_sync_reg[gi-1];
                        scl_sync_reg[gi] <= scl_sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    logic sda_s;
    logic scl_s;
    logic start_det;
    logic stop_det;
    logic scl_rise;
    logic scl_fall;

    assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
    assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
    assign start_det = sda_prev_reg & ~sda_s & scl_s;
    assign stop_det  = ~sda_prev_reg & sda_s & scl_s;
    // A START/STOP masks any SCL rise seen in the same cycle.
    assign scl_rise  = ~scl_prev_reg & scl_s & ~start_det & ~stop_det;
    assign scl_fall  = scl_prev_reg & ~scl_s;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [7:0]  shreg_reg, shreg_next;
    logic        rw_reg, rw_next;
    logic        sda_drive_reg, sda_drive_next;
    logic        busy_reg, busy_next;
    logic [7:0]  wr_data_reg, wr_data_next;
    logic        start_reg, start_next;
    logic        stop_reg, stop_next;
    logic        wr_valid_reg, wr_valid_next;
    logic        tx_req_reg, tx_req_next;
    logic [7:0]  byte_in;

    assign byte_in = {shreg_reg[6:0], sda_s};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sda_prev_reg  <= 1'b1;
            scl_prev_reg  <= 1'b1;
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            shreg_reg     <= 8'd0;
            rw_reg        <= 1'b0;
            sda_drive_reg <= 1'b1;
            busy_reg      <= 1'b0;
            wr_data_reg   <= 8'd0;
            start_reg     <= 1'b0;
            stop_reg      <= 1'b0;
            wr_valid_reg  <= 1'b0;
            tx_req_reg    <= 1'b0;
        end else begin
            sda_prev_reg  <= sda_s;
            scl_prev_reg  <= scl_s;
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shreg_reg     <= shreg_next;
            rw_reg        <= rw_next;
            sda_drive_reg <= sda_drive_next;
            busy_reg      <= busy_next;
            wr_data_reg   <= wr_data_next;
            start_reg     <= start_next;
            stop_reg      <= stop_next;
            wr_valid_reg  <= wr_valid_next;
            tx_req_reg    <= tx_req_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        shreg_next     = shreg_reg;
        rw_next        = rw_reg;
        sda_drive_next = sda_drive_reg;
        busy_next      = busy_reg;
        wr_data_next   = wr_data_reg;
        start_next     = 1'b0;
        stop_next      = 1'b0;
        wr_valid_next  = 1'b0;
        tx_req_next    = 1'b0;

        if (start_det) begin
            state_next     = ADDR;
            cnt_next       = 4'd0;
            start_next     = 1'b1;
            busy_next      = 1'b1;
            sda_drive_next = 1'b1;
        end else if (stop_det) begin
            state_next     = IDLE;
            cnt_next       = 4'd0;
            stop_next      = 1'b1;
            busy_next      = 1'b0;
            sda_drive_next = 1'b1;
        end else begin
            // User byte is captured while the request pulse is visible.
            if (tx_req_reg) begin
                shreg_next = i_tx_data;
            end
            case (state_reg)
                ADDR: begin
                    if (scl_rise) begin
                        shreg_next = byte_in;
                        if (cnt_reg == 4'd7) begin
                            cnt_next = 4'd0;
                            if (byte_in[7:1] == TARGET_ADDR) begin
                                state_next  = ADDR_ACK;
                                rw_next     = byte_in[0];
                                tx_req_next = byte_in[0];
                            end else begin
                                state_next = IGNORE;
                            end
                        end else begin
                            cnt_next = cnt_reg + 4'd1;
                        end
                    end
                end
                // cnt 0: first fall starts the ACK; cnt 1: second fall ends it.
                ADDR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (cnt_reg == 4'd0) begin
                            sda_drive_next = 1'b0;
                            cnt_next       = 4'd1;
                        end else begin
                            cnt_next = 4'd0;
                            if (state_reg == ADDR_ACK && rw_reg) begin
                                sda_drive_next = shreg_reg[7];
                                shreg_next     = {shreg_reg[6:0], 1'b0};
                                state_next     = RD_BYTE;
                            end else begin
                                sda_drive_next = 1'b1;
                                state_next     = WR_BYTE;
                            end
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise) begin
                        shreg_next = byte_in;
                        if (cnt_reg == 4'd7) begin
                            cnt_next      = 4'd0;
                            wr_data_next  = byte_in;
                            wr_valid_next = 1'b1;
                            state_next    = WR_ACK;
                        end else begin
                            cnt_next = cnt_reg + 4'd1;
                        end
                    end
                end
                RD_BYTE: begin
                    if (scl_fall) begin
                        if (cnt_reg == 4'd7) begin
                            cnt_next       = 4'd0;
                            sda_drive_next = 1'b1;
                            state_next     = RD_ACK;
                        end else begin
                            cnt_next       = cnt_reg + 4'd1;
                            sda_drive_next = shreg_reg[7];
                            shreg_next     = {shreg_reg[6:0], 1'b0};
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            tx_req_next = 1'b1;
                        end else begin
                            state_next = IGNORE;
                        end
                    end else if (scl_fall) begin
                        cnt_next       = 4'd0;
                        sda_drive_next = shreg_reg[7];
                        shreg_next     = {shreg_reg[6:0], 1'b0};
                        state_next     = RD_BYTE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_sda_drive = sda_drive_reg;
    assign o_start     = start_reg;
    assign o_stop      = stop_reg;
    assign o_busy      = busy_reg;
    assign o_wr_valid  = wr_valid_reg;
    assign o_wr_data   = wr_data_reg;
    assign o_tx_req    = tx_req_reg;

endmodule
